vga_stream_monitor: RTL



---
 rtl/vga_stream_monitor.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor
// Receive-side monitor for the game's VGA output. It samples RGB222 plus the
// active-high hsync/vsync pair and locks to the frame timing. Once locked it
// rebuilds pixel coordinates and a data-enable. It reports timing violations
// and publishes a checksum of every complete, error-free frame.
//
// Build option: define VGA_MON_INPUT_SYNC_EN to put a 2-flop synchronizer on
// all eight inputs, for an external or asynchronous source. Every output
// latency then grows from 1 to 3 cycles. With the macro undefined, the inputs
// are sampled directly and every output follows its input sample by 1 cycle.

module vga_stream_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_vga_r,
  input  logic [1:0]  i_vga_g,
  input  logic [1:0]  i_vga_b,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  output logic        o_locked,
  output logic        o_de,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_err,
  output logic [7:0]  o_err_count,
  output logic        o_frame_valid,
  output logic [23:0] o_frame_sum
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Counter-width copies of the timing constants. They keep every compare at
  // 11 bits.
  localparam logic [10:0] CNT_MAX     = 11'h7FF;
  localparam logic [10:0] H_TOTAL_C   = 11'(H_TOTAL);
  localparam logic [10:0] H_LAST_C    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_C    = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_BEG_C = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_END_C = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_LAST_C    = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNC_C    = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_BEG_C = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_END_C = 11'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_e;

  // ---------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------
  logic [7:0] rawIn;
  logic [7:0] sampled;

  assign rawIn = {i_vga_hsync, i_vga_vsync, i_vga_r, i_vga_g, i_vga_b};

`ifdef VGA_MON_INPUT_SYNC_EN
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  // Two-stage synchronizer that retimes all eight inputs into the pixel clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rawIn;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = rawIn;
`endif

  logic       hs;
  logic       vs;
  logic [5:0] pix;

  assign hs  = sampled[7];
  assign vs  = sampled[6];
  assign pix = sampled[5:0];

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  state_e      state_q;
  logic        hsPrev_q;
  logic        vsPrev_q;
  logic        vsPending_q, vsPending_d;
  logic [10:0] hCnt_q, hCnt_d;
  logic [10:0] vCnt_q, vCnt_d;
  logic [10:0] vsLines_q, vsLines_d;
  logic [23:0] acc_q, acc_d;

  logic        locked_q;
  logic        de_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic        err_q;
  logic [7:0]  errCount_q;
  logic        frameValid_q;
  logic [23:0] frameSum_q;

  // ---------------------------------------------------------------------
  // Edge detection and frame boundary
  // ---------------------------------------------------------------------
  logic hsRise;
  logic hsFall;
  logic vsRise;
  logic vsFall;
  logic boundary;

  assign hsRise   = hs & ~hsPrev_q;
  assign hsFall   = ~hs & hsPrev_q;
  assign vsRise   = vs & ~vsPrev_q;
  assign vsFall   = ~vs & vsPrev_q;
  // A frame starts on the first line start at or after the vsync rise.
  assign boundary = hsRise & (vsRise | vsPending_q);

  // Next values of the position counters. hCnt_d and vCnt_d are the h and v
  // of the sample taken in this cycle.
  always_comb begin
    hCnt_d = hCnt_q;
    if (hsRise) begin
      hCnt_d = '0;
    end else if (hCnt_q != CNT_MAX) begin
      hCnt_d = hCnt_q + 11'd1;
    end

    vCnt_d = vCnt_q;
    if (boundary) begin
      vCnt_d = '0;
    end else if (hsRise && (vCnt_q != CNT_MAX)) begin
      vCnt_d = vCnt_q + 11'd1;
    end

    vsPending_d = vsPending_q;
    if (boundary) begin
      vsPending_d = 1'b0;
    end else if (vsRise) begin
      vsPending_d = 1'b1;
    end

    vsLines_d = vsLines_q;
    if (vsRise) begin
      vsLines_d = hsRise ? 11'd1 : 11'd0;
    end else if (vs && hsRise && (vsLines_q != CNT_MAX)) begin
      vsLines_d = vsLines_q + 11'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Timing checks
  // ---------------------------------------------------------------------
  logic errLineShort;
  logic errLineLong;
  logic errHsWidth;
  logic errFrameShort;
  logic errFrameLong;
  logic errVsWidth;
  logic checkFail;

  assign errLineShort  = hsRise && (hCnt_q != H_LAST_C);
  assign errLineLong   = !hsRise && (hCnt_d == H_TOTAL_C);
  // The counter restarted at the rise, so at the fall it equals the high time.
  assign errHsWidth    = hsFall && (hCnt_d != H_SYNC_C);
  assign errFrameShort = boundary && (vCnt_q != V_LAST_C);
  assign errFrameLong  = hsRise && !boundary && (vCnt_q == V_LAST_C);
  assign errVsWidth    = vsFall && (vsLines_q != V_SYNC_C);

  assign checkFail = errLineShort | errLineLong | errHsWidth |
                     errFrameShort | errFrameLong | errVsWidth;

  // ---------------------------------------------------------------------
  // Active region, coordinates and checksum
  // ---------------------------------------------------------------------
  logic       colActive;
  logic       rowActive;
  logic       pixActive;
  logic [9:0] xPos;
  logic [9:0] yPos;
  logic       nextLocked;

  assign colActive = (hCnt_d >= H_ACT_BEG_C) && (hCnt_d < H_ACT_END_C);
  assign rowActive = (vCnt_d >= V_ACT_BEG_C) && (vCnt_d < V_ACT_END_C);
  assign pixActive = colActive & rowActive;
  assign xPos      = 10'(hCnt_d - H_ACT_BEG_C);
  assign yPos      = 10'(vCnt_d - V_ACT_BEG_C);

  // The monitor is locked after this cycle if it stays locked, or if it
  // finishes a clean measurement frame.
  assign nextLocked = !checkFail &&
                      ((state_q == LOCKED) || ((state_q == MEASURE) && boundary));

  // The checksum restarts with every frame. The boundary sample sits on line
  // 0, so it is never an active pixel.
  always_comb begin
    acc_d = acc_q;
    if (boundary) begin
      acc_d = '0;
    end else if (pixActive) begin
      acc_d = acc_q + {18'd0, pix};
    end
  end

  // Position counters, edge history and the running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsPrev_q    <= 1'b0;
      vsPrev_q    <= 1'b0;
      vsPending_q <= 1'b0;
      hCnt_q      <= '0;
      vCnt_q      <= '0;
      vsLines_q   <= '0;
      acc_q       <= '0;
    end else begin
      hsPrev_q    <= hs;
      vsPrev_q    <= vs;
      vsPending_q <= vsPending_d;
      hCnt_q      <= hCnt_d;
      vCnt_q      <= vCnt_d;
      vsLines_q   <= vsLines_d;
      acc_q       <= acc_d;
    end
  end

  // Lock FSM with its registered outputs. If a check fails on a boundary
  // cycle, the failure wins and no frame result is published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      locked_q     <= 1'b0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      err_q        <= 1'b0;
      errCount_q   <= '0;
      frameValid_q <= 1'b0;
      frameSum_q   <= '0;
    end else begin
      err_q        <= 1'b0;
      frameValid_q <= 1'b0;

      unique case (state_q)
        SEARCH: begin
          if (boundary) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (checkFail) begin
            state_q <= SEARCH;
          end else if (boundary) begin
            state_q      <= LOCKED;
            frameValid_q <= 1'b1;
            frameSum_q   <= acc_q;
          end
        end
        LOCKED: begin
          if (checkFail) begin
            state_q <= SEARCH;
            err_q   <= 1'b1;
            if (errCount_q != 8'hFF) begin
              errCount_q <= errCount_q + 8'd1;
            end
          end else if (boundary) begin
            frameValid_q <= 1'b1;
            frameSum_q   <= acc_q;
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase

      locked_q <= nextLocked;
      de_q     <= nextLocked & pixActive;
      x_q      <= (nextLocked && pixActive) ? xPos : 10'd0;
      y_q      <= (nextLocked && pixActive) ? yPos : 10'd0;
    end
  end

  assign o_locked      = locked_q;
  assign o_de          = de_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_err         = err_q;
  assign o_err_count   = errCount_q;
  assign o_frame_valid = frameValid_q;
  assign o_frame_sum   = frameSum_q;

endmodule
